cflog_writer: RTL and testbench

- Sits directly downstream of cflow and consumes its log-write events (cflow_hw_wen, cflow_log_ptr, cflow_src, cflow_dest, flush).
- Buffers each src/dest pair in a small FIFO and drains it, one 16-bit word per cycle, into the CFLog region of data memory through a ready-gated write port.
- The memory may be busy with CPU or DMA, so writes can stall.
- On flush, drains all pending entries before signalling completion, so the TCB always reads a complete CFLog.

---
 rtl/cflog_pkg.sv | 28 ++
 rtl/cflog_fifo.sv | 52 +++++
 rtl/cflog_writer.sv | 137 +++++++++++++
 tb/tb_cflog_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cflog_pkg.sv
// Shared types and defaults for the CFLog writer; LOG_BASE/LOG_SIZE defaults
// must stay in step with cflow.
package cflog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WR_SRC     = 2'd1,
        ST_WR_DEST    = 2'd2,
        ST_FLUSH_DONE = 2'd3
    } cflog_state_e;

    localparam int unsigned ENTRY_W        = 48;
    localparam logic [15:0] CFLOG_BASE_DEF = 16'h0400;
    localparam logic [15:0] CFLOG_SIZE_DEF = 16'h0080;

    typedef struct packed {
        logic [15:0] ptr;
        logic [15:0] src;
        logic [15:0] dest;
    } cflog_entry_t;

    // Byte address of a 16-bit CFLog word; wraps modulo 2^16.
    function automatic logic [15:0] slot_addr(input logic [15:0] base,
                                              input logic [15:0] idx);
        return base + {idx[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/cflog_fifo.sv
// Synchronous FIFO holding pending CFLog entries; a push while full is taken
// when a pop happens in the same cycle.
module cflog_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     puc_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cflog_writer.sv
// Buffers cflow log events and drains them as src/dest word writes into the
// CFLog region, with stall tolerance and a flush-complete handshake.
module cflog_writer
    import cflog_pkg::*;
#(
    parameter logic [15:0] LOG_SIZE   = CFLOG_SIZE_DEF,
    parameter logic [15:0] LOG_BASE   = CFLOG_BASE_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        puc_n,
    input  logic        hw_wen,
    input  logic [15:0] log_ptr,
    input  logic [15:0] src,
    input  logic [15:0] dest,
    input  logic        flush,
    input  logic        mem_ready,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        busy,
    output logic        flush_done,
    output logic        overflow,
    output logic        bound_err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    cflog_state_e       state;
    cflog_entry_t       push_e;
    cflog_entry_t       head_e;
    logic [ENTRY_W-1:0] head_raw;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               bound_bad;
    logic               pop;
    logic               push_ok;
    logic               more_after_pop;
    logic               flush_q;
    logic               flush_pend;

    assign push_e         = '{ptr: log_ptr, src: src, dest: dest};
    assign head_e         = cflog_entry_t'(head_raw);
    assign bound_bad      = log_ptr > (LOG_SIZE - 16'd2);
    assign pop            = (state == ST_WR_DEST) && mem_ready;
    assign push_ok        = hw_wen && !bound_bad && (!fifo_full || pop);
    assign more_after_pop = (fifo_count > CW'(1)) || push_ok;
    assign busy           = !fifo_empty || (state == ST_WR_SRC) || (state == ST_WR_DEST);

    cflog_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .puc_n (puc_n),
        .push  (push_ok),
        .pop   (pop),
        .wdata (push_e),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head_raw)
    );

    // Address/data come straight from the FIFO head, which cannot move until
    // the dest word is accepted, so they hold stable across stalls.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_WR_SRC: begin
                mem_addr  = slot_addr(LOG_BASE, head_e.ptr);
                mem_wdata = head_e.src;
            end
            ST_WR_DEST: begin
                mem_addr  = slot_addr(LOG_BASE, head_e.ptr + 16'd1);
                mem_wdata = head_e.dest;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            state      <= ST_IDLE;
            mem_wr     <= 1'b0;
            flush_done <= 1'b0;
            flush_q    <= 1'b0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
            bound_err  <= 1'b0;
        end else begin
            flush_q    <= flush;
            flush_done <= 1'b0;
            if (flush && !flush_q) flush_pend <= 1'b1;

            if (hw_wen && bound_bad)
                bound_err <= 1'b1;
            else if (hw_wen && fifo_full && !pop)
                overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state  <= ST_WR_SRC;
                        mem_wr <= 1'b1;
                    end else if (flush_pend) begin
                        state      <= ST_FLUSH_DONE;
                        flush_done <= 1'b1;
                        flush_pend <= 1'b0;
                    end
                end
                ST_WR_SRC: begin
                    if (mem_ready) state <= ST_WR_DEST;
                end
                ST_WR_DEST: begin
                    if (mem_ready) begin
                        if (more_after_pop) begin
                            state <= ST_WR_SRC;
                        end else if (flush_pend) begin
                            state      <= ST_FLUSH_DONE;
                            mem_wr     <= 1'b0;
                            flush_done <= 1'b1;
                            flush_pend <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            mem_wr <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cflog_writer.sv
// Directed bench for cflog_writer: a write-queue model checked every cycle,
// plus literal expectations for each scenario.
module tb_cflog_writer;

    localparam logic [15:0] LOG_SIZE = 16'h0080;
    localparam logic [15:0] LOG_BASE = 16'h0400;
    localparam int unsigned DEPTH    = 4;

    logic        clk = 1'b0;
    logic        puc_n;
    logic        hw_wen;
    logic [15:0] log_ptr;
    logic [15:0] src;
    logic [15:0] dest;
    logic        flush;
    logic        mem_ready;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        flush_done;
    logic        overflow;
    logic        bound_err;

    cflog_writer #(
        .LOG_SIZE   (LOG_SIZE),
        .LOG_BASE   (LOG_BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .puc_n      (puc_n),
        .hw_wen     (hw_wen),
        .log_ptr    (log_ptr),
        .src        (src),
        .dest       (dest),
        .flush      (flush),
        .mem_ready  (mem_ready),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .flush_done (flush_done),
        .overflow   (overflow),
        .bound_err  (bound_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         wr_log[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned last_push_cyc = 0;
    int unsigned fd_count = 0;
    int unsigned wr_cycles = 0;
    bit          m_ovf = 0;
    bit          m_bnd = 0;
    int unsigned pending;
    bit          acc;
    bit          pop_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Model: a log entry becomes two expected writes; entries still owed a
    // dest write occupy the buffer.
    always @(negedge clk) begin
        cyc++;
        if (!puc_n) begin
            exp_q.delete();
            m_ovf = 0;
            m_bnd = 0;
            chk("rst_mem_wr", mem_wr, 0);
            chk("rst_busy", busy, 0);
            chk("rst_flush_done", flush_done, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_bound_err", bound_err, 0);
        end else begin
            chk("busy", busy, exp_q.size() != 0);
            chk("overflow", overflow, m_ovf);
            chk("bound_err", bound_err, m_bnd);
            if (mem_wr) begin
                wr_cycles++;
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 1, 0);
                end else begin
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_wdata", mem_wdata, exp_q[0].data);
                end
            end
            if (flush_done) begin
                fd_count++;
                chk("flush_done_log_complete", exp_q.size(), 0);
            end
            acc     = mem_wr && mem_ready && exp_q.size() != 0;
            pending = (exp_q.size() + 1) / 2;
            pop_now = acc && (exp_q.size() % 2 == 1);
            if (hw_wen) begin
                last_push_cyc = cyc;
                if (log_ptr > LOG_SIZE - 16'd2)
                    m_bnd = 1;
                else if (pending == DEPTH && !pop_now)
                    m_ovf = 1;
                else begin
                    exp_q.push_back('{LOG_BASE + 16'(2 * log_ptr), src, 0});
                    exp_q.push_back('{LOG_BASE + 16'(2 * log_ptr) + 16'd2, dest, 0});
                end
            end
            if (acc) begin
                wr_log.push_back('{mem_addr, mem_wdata, cyc});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] p, input logic [15:0] s, input logic [15:0] d);
        hw_wen  = 1'b1;
        log_ptr = p;
        src     = s;
        dest    = d;
        tick(1);
        hw_wen  = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            tick(1);
            n++;
        end
        chk("drain_timeout", busy || exp_q.size() != 0, 0);
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        puc_n = 1'b0; hw_wen = 1'b0; log_ptr = '0; src = '0; dest = '0;
        flush = 1'b0; mem_ready = 1'b1;
        tick(3);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        puc_n = 1'b1;
        tick(2);

        // Single entry, ready memory
        wr_log.delete(); wr_cycles = 0;
        push(16'h0004, 16'hE100, 16'hE200);
        wait_idle(20);
        chk("t1_nwrites", wr_log.size(), 2);
        chk("t1_src_addr", wr_log[0].addr, 16'h0408);
        chk("t1_src_data", wr_log[0].data, 16'hE100);
        chk("t1_dst_addr", wr_log[1].addr, 16'h040A);
        chk("t1_dst_data", wr_log[1].data, 16'hE200);
        chk("t1_latency", wr_log[0].cyc - last_push_cyc, 2);
        chk("t1_b2b", wr_log[1].cyc - wr_log[0].cyc, 1);
        chk("t1_busy_end", busy, 0);

        // Stall in WR_SRC for 3 cycles
        wr_log.delete(); wr_cycles = 0;
        mem_ready = 1'b0;
        push(16'h0004, 16'hE100, 16'hE200);
        tick(4);
        mem_ready = 1'b1;
        wait_idle(20);
        chk("t2_nwrites", wr_log.size(), 2);
        chk("t2_wr_cycles", wr_cycles, 5);
        chk("t2_src_cyc", wr_log[0].cyc - last_push_cyc, 5);
        chk("t2_dst_addr", wr_log[1].addr, 16'h040A);

        // Burst of 6 into a depth-4 buffer while memory is busy
        wr_log.delete();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(16'(2 * i), 16'hA000 + 16'(i), 16'hB000 + 16'(i));
            chk("t3_overflow_step", overflow, (i >= 4) ? 1 : 0);
        end
        mem_ready = 1'b1;
        wait_idle(40);
        chk("t3_nwrites", wr_log.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk("t3_src_addr", wr_log[2*i].addr, 16'h0400 + 16'(4 * i));
            chk("t3_src_data", wr_log[2*i].data, 16'hA000 + 16'(i));
            chk("t3_dst_addr", wr_log[2*i+1].addr, 16'h0402 + 16'(4 * i));
            chk("t3_dst_data", wr_log[2*i+1].data, 16'hB000 + 16'(i));
        end

        // Bound check: last legal src slot is LOG_SIZE-2
        wr_log.delete();
        push(16'h007F, 16'h1111, 16'h2222);
        tick(3);
        chk("t4_bound_err", bound_err, 1);
        chk("t4_no_write", wr_log.size(), 0);
        push(16'h007E, 16'h3333, 16'h4444);
        wait_idle(20);
        chk("t4_nwrites", wr_log.size(), 2);
        chk("t4_src_addr", wr_log[0].addr, 16'h04FC);
        chk("t4_dst_addr", wr_log[1].addr, 16'h04FE);

        // Flush with pending entries and a push during the drain
        wr_log.delete(); fd_count = 0;
        mem_ready = 1'b0;
        push(16'h0010, 16'hC000, 16'hD000);
        push(16'h0012, 16'hC001, 16'hD001);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        mem_ready = 1'b1;
        tick(1);
        push(16'h0014, 16'hC002, 16'hD002);
        for (int n = 0; n < 30 && fd_count == 0; n++) tick(1);
        tick(2);
        chk("t5_flush_done_count", fd_count, 1);
        chk("t5_nwrites", wr_log.size(), 6);
        chk("t5_last_addr", wr_log[5].addr, 16'h042A);
        chk("t5_last_data", wr_log[5].data, 16'hD002);
        fd_count = 0;
        flush = 1'b1;
        tick(10);
        flush = 1'b0;
        tick(2);
        chk("t5_held_flush_pulses", fd_count, 1);

        // Full buffer with pops coinciding with pushes
        wr_log.delete();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h0030 + 16'(2 * i), 16'h5000 + 16'(i), 16'h6000 + 16'(i));
        mem_ready = 1'b1;
        for (int i = 4; i < 8; i++) push(16'h0030 + 16'(2 * i), 16'h5000 + 16'(i), 16'h6000 + 16'(i));
        wait_idle(40);
        chk("t7_nwrites", wr_log.size(), 12);
        chk("t7_entry5_src", wr_log[8].data, 16'h5005);
        chk("t7_entry6_src", wr_log[10].data, 16'h5007);

        // Asynchronous reset while stalled in WR_DEST
        mem_ready = 1'b0;
        push(16'h0020, 16'h7000, 16'h7001);
        tick(1);
        mem_ready = 1'b1;
        tick(1);
        mem_ready = 1'b0;
        tick(1);
        chk("t6_in_dest_addr", mem_addr, 16'h0442);
        wr_log.delete();
        puc_n = 1'b0;
        #1;
        chk("t6_async_mem_wr", mem_wr, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_overflow", overflow, 0);
        chk("t6_async_bound_err", bound_err, 0);
        tick(2);
        puc_n = 1'b1;
        mem_ready = 1'b1;
        tick(6);
        chk("t6_no_write_after", wr_log.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
